// File: rtl/cnn_pkg.sv
// Shared CNN definitions: control-state encoding, default widths and CONV1 map geometry.
// The read-address generator uses the same geometry constants.
package cnn_pkg;

  localparam int DWL_DEF           = 16;
  localparam int AWL_DEF           = 9;
  localparam int CONV1_OUT_W       = 7;
  localparam int CONV1_OUT_H       = 8;
  localparam int CONV1_BANK_OFFSET = 252;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrlState_t;

endpackage

// File: rtl/conv1_write_controller_if.sv
// Conv-result input stream and feature-map write port of the CONV1 write controller.
// The bus has no backpressure. iVALID qualifies iDATA and every valid beat seen in RUN is consumed.
// oWR_EN is a one-cycle strobe. oWR_ADDR and oWR_DATA hold their values between strobes.
interface conv1_write_controller_if
  import cnn_pkg::*;
#(
  parameter int DWL = DWL_DEF,
  parameter int AWL = AWL_DEF
);
  logic                  iSTART;
  logic                  iBANK;
  logic                  iVALID;
  logic signed [DWL-1:0] iDATA;
  logic                  oWR_EN;
  logic [AWL-1:0]        oWR_ADDR;
  logic signed [DWL-1:0] oWR_DATA;
  logic                  oBUSY;
  logic                  oDONE;
  ctrlState_t            dbgState;

  modport master (
    output iSTART, iBANK, iVALID, iDATA,
    input  oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oDONE, dbgState
  );

  modport slave (
    input  iSTART, iBANK, iVALID, iDATA,
    output oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oDONE, dbgState
  );
endinterface

// File: rtl/conv1_write_controller_pool_relu_unit.sv
// 2x2 max-pool over four consecutive accepted values, followed by ReLU.
// Emits a registered one-cycle pixelValid together with the pooled value.
module pool_relu_unit #(
  parameter int DWL = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  accept,
  input  logic signed [DWL-1:0] data,
  output logic                  lastBeat,
  output logic                  pixelValid,
  output logic signed [DWL-1:0] pixelData
);
  logic [1:0]            poolCnt;
  logic signed [DWL-1:0] maxReg;
  logic signed [DWL-1:0] runMax;

  // The first beat of a window always loads. On a tie the earlier value is kept.
  always_comb begin
    runMax = maxReg;
    if (poolCnt == 2'd0 || data > maxReg) runMax = data;
  end

  assign lastBeat = accept && (poolCnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      poolCnt    <= 2'd0;
      maxReg     <= '0;
      pixelValid <= 1'b0;
      pixelData  <= '0;
    end else begin
      pixelValid <= 1'b0;
      if (clear) begin
        poolCnt <= 2'd0;
      end else if (accept) begin
        poolCnt <= poolCnt + 2'd1;
        maxReg  <= runMax;
        if (lastBeat) begin
          pixelValid <= 1'b1;
          pixelData  <= runMax[DWL-1] ? '0 : runMax;
        end
      end
    end
  end
endmodule

// File: rtl/conv1_write_controller.sv
// CONV1 write controller: frame FSM, raster col/row counters and write-address generation.
// Pooling and ReLU are delegated to pool_relu_unit.
module conv1_write_controller
  import cnn_pkg::*;
#(
  parameter int DWL         = DWL_DEF,
  parameter int AWL         = AWL_DEF,
  parameter int OUT_W       = CONV1_OUT_W,
  parameter int OUT_H       = CONV1_OUT_H,
  parameter int BANK_OFFSET = CONV1_BANK_OFFSET
) (
  input logic                    iCLK,
  input logic                    iRST,
  conv1_write_controller_if.slave bus
);
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam bit ADDR_FITS = (BANK_OFFSET + OUT_W * OUT_H) <= (1 << AWL);

  ctrlState_t            stateReg, stateNext;
  logic [CW-1:0]         colCnt;
  logic [RW-1:0]         rowCnt;
  logic [AWL-1:0]        rowBase;
  logic [AWL-1:0]        wrAddr;
  logic                  accept, lastBeat, pixelValid;
  logic signed [DWL-1:0] pixelData;
  logic                  endOfRow, lastPos;

  assign accept   = bus.iVALID && !bus.iSTART && (stateReg == RUN);
  assign endOfRow = (colCnt == CW'(OUT_W - 1));
  assign lastPos  = endOfRow && (rowCnt == RW'(OUT_H - 1));

  pool_relu_unit #(.DWL(DWL)) uPool (
    .clk        (iCLK),
    .rst        (iRST),
    .clear      (bus.iSTART),
    .accept     (accept),
    .data       (bus.iDATA),
    .lastBeat   (lastBeat),
    .pixelValid (pixelValid),
    .pixelData  (pixelData)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) stateReg <= IDLE;
    else      stateReg <= stateNext;
  end

  // DONE is entered at the end of the final write cycle, so oDONE follows the last strobe.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (bus.iSTART) stateNext = RUN;
      RUN:     if (!bus.iSTART && pixelValid && lastPos) stateNext = DONE;
      DONE:    if (bus.iSTART) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  // Row advance adds OUT_W to a running base instead of multiplying row by width.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      colCnt  <= '0;
      rowCnt  <= '0;
      rowBase <= '0;
      wrAddr  <= '0;
    end else if (bus.iSTART) begin
      colCnt  <= '0;
      rowCnt  <= '0;
      rowBase <= bus.iBANK ? AWL'(BANK_OFFSET) : '0;
    end else begin
      if (lastBeat) wrAddr <= rowBase + AWL'(colCnt);
      if (pixelValid) begin
        if (endOfRow) begin
          colCnt  <= '0;
          rowCnt  <= rowCnt + 1'b1;
          rowBase <= rowBase + AWL'(OUT_W);
        end else begin
          colCnt <= colCnt + 1'b1;
        end
      end
    end
  end

  assign bus.oWR_EN   = pixelValid;
  assign bus.oWR_ADDR = wrAddr;
  assign bus.oWR_DATA = pixelData;
  assign bus.oBUSY    = (stateReg == RUN);
  assign bus.oDONE    = (stateReg == DONE);
  assign bus.dbgState = stateReg;

  addrRangeOk: assert property (@(posedge iCLK) ADDR_FITS);
endmodule

// File: tb/tb_conv1_write_controller.sv
// Bench for conv1_write_controller: directed scenarios plus random traffic.
// Every cycle is checked against a frame-level reference model.
module tb_conv1_write_controller;
  import cnn_pkg::*;

  localparam int DWL  = 16;
  localparam int AWL  = 9;
  localparam int OW   = 7;
  localparam int OH   = 8;
  localparam int BOFF = 252;
  localparam int NPIX = OW * OH;

  // clock / reset
  logic iCLK = 1'b0;
  logic iRST;
  always #5 iCLK = ~iCLK;

  conv1_write_controller_if #(.DWL(DWL), .AWL(AWL)) bus ();

  conv1_write_controller #(
    .DWL(DWL), .AWL(AWL), .OUT_W(OW), .OUT_H(OH), .BANK_OFFSET(BOFF)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [AWL-1:0] exp_q[$];
  int wrCount = 0;
  int lastWrAddr = 0;
  int lastWrData = 0;
  int wrLog[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // reference model: a frame is a linear list of NPIX pixels, four samples per pixel
  int mState = 0;  // 0 idle, 1 run, 2 done
  int mBase = 0, mPix = 0, mN = 0;
  int mBuf[4];
  bit pendDone = 0;
  bit eEn = 0;
  logic [AWL-1:0] eAddr = '0;
  logic [DWL-1:0] eData = '0;

  task automatic model_step(input bit rst, input bit start, input bit bank, input bit valid, input int d);
    bit wasRun;
    int m;
    eEn = 1'b0;
    if (rst) begin
      mState = 0; mN = 0; mPix = 0; mBase = 0; pendDone = 0;
      eAddr = '0; eData = '0;
    end else if (start) begin
      mState = 1; mN = 0; mPix = 0; pendDone = 0;
      mBase = bank ? BOFF : 0;
    end else begin
      wasRun = (mState == 1);
      if (pendDone) begin
        mState = 2;
        pendDone = 0;
      end
      if (wasRun && valid) begin
        mBuf[mN] = d;
        mN++;
        if (mN == 4) begin
          m = mBuf[0];
          for (int k = 1; k < 4; k++) if (mBuf[k] > m) m = mBuf[k];
          eEn = 1'b1;
          eData = (m < 0) ? '0 : DWL'(m);
          eAddr = AWL'(mBase + mPix);
          exp_q.push_back(eAddr);
          mPix++;
          mN = 0;
          if (mPix == NPIX) pendDone = 1;
        end
      end
    end
  endtask

  // driver: apply inputs, clock, update model, compare #1 after the edge
  task automatic cycle(input bit rst, input bit start, input bit bank, input bit valid, input int d);
    ctrlState_t es;
    iRST       = rst;
    bus.iSTART = start;
    bus.iBANK  = bank;
    bus.iVALID = valid;
    bus.iDATA  = DWL'(d);
    @(posedge iCLK);
    model_step(rst, start, bank, valid, d);
    #1;
    es = (mState == 1) ? RUN : (mState == 2) ? DONE : IDLE;
    check_val("wr_en", {31'd0, bus.oWR_EN}, {31'd0, eEn});
    check_val("wr_addr", {23'd0, bus.oWR_ADDR}, {23'd0, eAddr});
    check_val("wr_data", {16'd0, bus.oWR_DATA}, {16'd0, eData});
    check_val("busy", {31'd0, bus.oBUSY}, {31'd0, (mState == 1)});
    check_val("done", {31'd0, bus.oDONE}, {31'd0, (mState == 2)});
    check_val("state", 32'(bus.dbgState), 32'(es));
    if (bus.oWR_EN) begin
      wrCount++;
      lastWrAddr = int'(bus.oWR_ADDR);
      lastWrData = int'(bus.oWR_DATA);
      wrLog.push_back(int'(bus.oWR_ADDR));
      if (exp_q.size() > 0) check_val("order", {23'd0, bus.oWR_ADDR}, {23'd0, exp_q.pop_front()});
      else check_val("unexpected_wr", 32'd1, 32'd0);
    end else if (eEn && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic push_vals(input int a, input int b, input int c, input int e);
    cycle(0, 0, 0, 1, a);
    cycle(0, 0, 0, 1, b);
    cycle(0, 0, 0, 1, c);
    cycle(0, 0, 0, 1, e);
  endtask

  function automatic int rand_data();
    logic [DWL-1:0] r;
    r = DWL'($urandom);
    if ($urandom_range(0, 7) == 0) r = $urandom_range(0, 1) ? 16'h7fff : 16'h8000;
    return int'($signed(r));
  endfunction

  initial begin
    int w0, l0, sent, guard;
    iRST = 1'b1;
    bus.iSTART = 1'b0; bus.iBANK = 1'b0; bus.iVALID = 1'b0; bus.iDATA = '0;

    // reset
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 99);
    check_val("rst_idle_done", {31'd0, bus.oDONE}, 32'd0);

    // single pixel, then negative and extreme pixels
    cycle(0, 1, 0, 0, 0);
    w0 = wrCount;
    push_vals(5, -3, 12, 7);
    check_val("single_cnt", wrCount - w0, 1);
    check_val("single_addr", lastWrAddr, 0);
    check_val("single_data", lastWrData, 12);
    cycle(0, 0, 0, 0, 0);
    check_val("single_en_low", {31'd0, bus.oWR_EN}, 32'd0);
    push_vals(-8, -2, -5, -1);
    check_val("neg_data", lastWrData, 0);
    check_val("neg_addr", lastWrAddr, 1);
    push_vals(-32768, 32767, 0, -1);
    check_val("ext_data", lastWrData, 32767);

    // full frame on bank 1 with random gaps
    cycle(0, 1, 1, 0, 0);
    w0 = wrCount; l0 = wrLog.size(); sent = 0; guard = 0;
    while (sent < 4 * NPIX && guard < 4000) begin
      guard++;
      if ($urandom_range(0, 3) == 0) cycle(0, 0, 0, 0, rand_data());
      else begin
        cycle(0, 0, 0, 1, rand_data());
        sent++;
      end
    end
    check_val("frame_sent", sent, 4 * NPIX);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check_val("frame_writes", wrCount - w0, NPIX);
    if (wrLog.size() >= l0 + NPIX) begin
      check_val("frame_first", wrLog[l0], BOFF);
      check_val("frame_r1c0", wrLog[l0 + OW], BOFF + OW);
      check_val("frame_last", wrLog[l0 + NPIX - 1], BOFF + NPIX - 1);
    end else check_val("frame_log", wrLog.size() - l0, NPIX);
    check_val("done_level", {31'd0, bus.oDONE}, 32'd1);
    w0 = wrCount;
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 100 + i);
    check_val("done_no_wr", wrCount - w0, 0);
    check_val("done_hold", {31'd0, bus.oDONE}, 32'd1);

    // abort mid-pixel, restart on bank 0
    cycle(0, 1, 1, 0, 0);
    w0 = wrCount;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 10 + i);
    cycle(0, 1, 0, 0, 0);
    check_val("abort_cnt", wrCount - w0, 1);
    push_vals(3, 9, 1, 2);
    check_val("abort_addr", lastWrAddr, 0);
    check_val("abort_data", lastWrData, 9);

    // same-cycle start and valid: datum dropped
    cycle(0, 1, 0, 1, 1000);
    w0 = wrCount;
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 2);
    cycle(0, 0, 0, 1, 3);
    check_val("drop_no_wr", wrCount - w0, 0);
    cycle(0, 0, 0, 1, 4);
    check_val("drop_wr", wrCount - w0, 1);
    check_val("drop_data", lastWrData, 4);

    // mid-frame reset
    cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 50 + i);
    cycle(1, 0, 0, 0, 0);
    check_val("mrst_busy", {31'd0, bus.oBUSY}, 32'd0);
    check_val("mrst_addr", {23'd0, bus.oWR_ADDR}, 32'd0);
    w0 = wrCount;
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 77);
    check_val("mrst_ignore", wrCount - w0, 0);
    cycle(0, 1, 0, 0, 0);
    push_vals(6, 6, 6, 6);
    check_val("mrst_addr0", lastWrAddr, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), rand_data());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
